// File: rtl/reqgnt_server.sv
// reqgnt_server: in-order request queue with age-forced grants.
// Oldest request is granted on svc_ready or once it is MAX_LAT cycles old.
module reqgnt_server #(
  parameter int DEPTH   = 8,
  parameter int MAX_LAT = 8,
  parameter int ID_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [ID_W-1:0]            req_id,
  input  logic                       svc_ready,
  output logic                       gnt,
  output logic [ID_W-1:0]            gnt_id,
  output logic                       gnt_forced,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(MAX_LAT+1) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0] id_mem    [DEPTH];
  logic [TW-1:0]   stamp_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [TW-1:0]   ts;
  logic [TW-1:0]   head_age;
  logic [CW-1:0]   cnt;
  logic            accept;

  function automatic logic [PW-1:0] inc_ptr(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Age wraps modulo 2^TW, which always exceeds MAX_LAT.
  always_comb begin
    full        = (cnt == CW'(DEPTH));
    empty       = (cnt == '0);
    head_age    = ts - stamp_mem[rd_ptr];
    gnt         = !rst && !empty &&
                  (svc_ready || head_age >= TW'(MAX_LAT));
    gnt_id      = id_mem[rd_ptr];
    gnt_forced  = gnt && !svc_ready;
    accept      = req && (!full || gnt);
    outstanding = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      ts       <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + TW'(1);
      if (gnt)
        rd_ptr <= inc_ptr(rd_ptr);
      if (accept)
        wr_ptr <= inc_ptr(wr_ptr);
      if (req && !accept)
        overflow <= 1'b1;
      case ({accept, gnt})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      id_mem[wr_ptr]    <= req_id;
      stamp_mem[wr_ptr] <= ts;
    end
  end

endmodule

// File: tb/tb_reqgnt_server.sv
// tb_reqgnt_server: directed and random checks of reqgnt_server
// against a queue-of-arrival-times reference model.
module tb_reqgnt_server;
  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       svc_ready = 1'b0;
  logic [3:0] req_id = '0;

  logic       gnt8, gf8, full8, empty8, ovf8;
  logic [3:0] gid8;
  logic [3:0] out8;
  logic       gnt4, gf4, full4, empty4, ovf4;
  logic [3:0] gid4;
  logic [2:0] out4;

  typedef struct {
    logic [3:0] id;
    int         t;
  } ent_t;

  ent_t mq [2][$];
  bit   mg   [2];
  bit   movf [2];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  reqgnt_server #(.DEPTH(8), .MAX_LAT(8), .ID_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .req(req), .req_id(req_id),
    .svc_ready(svc_ready), .gnt(gnt8), .gnt_id(gid8),
    .gnt_forced(gf8), .outstanding(out8), .full(full8),
    .empty(empty8), .overflow(ovf8)
  );

  reqgnt_server #(.DEPTH(4), .MAX_LAT(8), .ID_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .req_id(req_id),
    .svc_ready(svc_ready), .gnt(gnt4), .gnt_id(gid4),
    .gnt_forced(gf4), .outstanding(out4), .full(full4),
    .empty(empty4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  task automatic model_eval();
    for (int k = 0; k < 2; k++)
      mg[k] = !rst && mq[k].size() > 0 &&
              (svc_ready || (cyc - mq[k][0].t) >= LAT);
  endtask

  task automatic model_update();
    ent_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        movf[k] = 1'b0;
      end else begin
        if (mg[k])
          void'(mq[k].pop_front());
        if (req) begin
          if (mq[k].size() < dep(k)) begin
            e.id = req_id;
            e.t  = cyc;
            mq[k].push_back(e);
          end else begin
            movf[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cyc_begin(input logic r, input logic [3:0] id,
                           input logic sr, input logic rs);
    req = r;
    req_id = id;
    svc_ready = sr;
    rst = rs;
    @(negedge clk);
    model_eval();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc_begin(1'b0, 4'h0, 1'b1, 1'b1);
      n_chk++;
      if ({gnt8, gnt4} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_gnt: got %b want 00", {gnt8, gnt4});
      end
      cyc_end();
    end
    cyc_begin(1'b0, 4'h0, 1'b1, 1'b0);
    n_chk++;
    if ({out8, empty8, full8, ovf8, gnt8} !== {4'd0, 4'b1000}) begin
      n_fail++;
      $display("FAIL rst_state8: out=%0d e=%b f=%b o=%b g=%b want 0 1 0 0 0",
               out8, empty8, full8, ovf8, gnt8);
    end
    n_chk++;
    if ({out4, empty4, full4, ovf4, gnt4} !== {3'd0, 4'b1000}) begin
      n_fail++;
      $display("FAIL rst_state4: out=%0d e=%b f=%b o=%b g=%b want 0 1 0 0 0",
               out4, empty4, full4, ovf4, gnt4);
    end
    cyc_end();
  endtask

  task automatic test_single();
    cyc_begin(1'b1, 4'h3, 1'b1, 1'b0);
    n_chk++;
    if (gnt8 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_arrive: gnt=%b want 0", gnt8);
    end
    cyc_end();
    cyc_begin(1'b0, 4'h0, 1'b1, 1'b0);
    n_chk++;
    if ({gnt8, gid8, gf8} !== {1'b1, 4'h3, 1'b0}) begin
      n_fail++;
      $display("FAIL single_gnt: gnt=%b id=%h frc=%b want 1 3 0",
               gnt8, gid8, gf8);
    end
    cyc_end();
    cyc_begin(1'b0, 4'h0, 1'b1, 1'b0);
    n_chk++;
    if ({gnt8, out8, empty8} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_drain: gnt=%b out=%0d e=%b want 0 0 1",
               gnt8, out8, empty8);
    end
    cyc_end();
  endtask

  task automatic test_forced();
    cyc_begin(1'b1, 4'hA, 1'b0, 1'b0);
    cyc_end();
    for (int i = 1; i <= LAT; i++) begin
      cyc_begin(1'b0, 4'h0, 1'b0, 1'b0);
      n_chk++;
      if (i < LAT) begin
        if (gnt8 !== 1'b0) begin
          n_fail++;
          $display("FAIL forced_early age=%0d: gnt=%b want 0", i, gnt8);
        end
      end else if ({gnt8, gf8, gid8} !== {2'b11, 4'hA}) begin
        n_fail++;
        $display("FAIL forced_gnt: gnt=%b frc=%b id=%h want 1 1 a",
                 gnt8, gf8, gid8);
      end
      cyc_end();
    end
  endtask

  task automatic test_stream();
    int peak = 0;
    for (int c = 0; c < 25; c++) begin
      cyc_begin(c < 16, 4'(c), 1'b0, 1'b0);
      n_chk++;
      if (c >= 8 && c <= 23) begin
        if ({gnt8, gf8, gid8} !== {2'b11, 4'(c - 8)}) begin
          n_fail++;
          $display("FAIL stream c=%0d: gnt=%b frc=%b id=%h want 1 1 %h",
                   c, gnt8, gf8, gid8, 4'(c - 8));
        end
      end else if (gnt8 !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_idle c=%0d: gnt=%b want 0", c, gnt8);
      end
      if (int'(out8) > peak)
        peak = int'(out8);
      cyc_end();
    end
    n_chk++;
    if (peak != 8 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_peak: peak=%0d ovf=%b want 8 0", peak, ovf8);
    end
  endtask

  task automatic test_full();
    int ngr = 0;
    cyc_begin(1'b0, 4'h0, 1'b0, 1'b1);
    cyc_end();
    for (int c = 0; c < 14; c++) begin
      cyc_begin(c < 5, 4'(c + 1), 1'b0, 1'b0);
      n_chk++;
      if (c >= 8 && c <= 11) begin
        if ({gnt4, gid4} !== {1'b1, 4'(c - 7)}) begin
          n_fail++;
          $display("FAIL full_gnt c=%0d: gnt=%b id=%h want 1 %h",
                   c, gnt4, gid4, 4'(c - 7));
        end
      end else if (gnt4 !== 1'b0) begin
        n_fail++;
        $display("FAIL full_idle c=%0d: gnt=%b want 0", c, gnt4);
      end
      n_chk++;
      if (ovf4 !== (c >= 5)) begin
        n_fail++;
        $display("FAIL full_ovf c=%0d: ovf=%b want %b", c, ovf4, c >= 5);
      end
      if (c == 4) begin
        n_chk++;
        if ({full4, out4} !== {1'b1, 3'd4}) begin
          n_fail++;
          $display("FAIL full_flag: full=%b out=%0d want 1 4", full4, out4);
        end
      end
      if (gnt4 === 1'b1)
        ngr++;
      cyc_end();
    end
    n_chk++;
    if (ngr != 4) begin
      n_fail++;
      $display("FAIL full_count: grants=%0d want 4", ngr);
    end
  endtask

  task automatic test_reset_mid();
    cyc_begin(1'b0, 4'h0, 1'b0, 1'b1);
    cyc_end();
    for (int c = 0; c < 3; c++) begin
      cyc_begin(1'b1, 4'(c + 7), 1'b0, 1'b0);
      cyc_end();
    end
    cyc_begin(1'b0, 4'h0, 1'b1, 1'b1);
    n_chk++;
    if ({gnt8, gnt4} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_gate: gnt=%b%b want 00", gnt8, gnt4);
    end
    cyc_end();
    for (int c = 0; c < 12; c++) begin
      cyc_begin(1'b0, 4'h0, 1'b1, 1'b0);
      n_chk++;
      if ({gnt8, out8, empty8} !== {1'b0, 4'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL midrst_after c=%0d: gnt=%b out=%0d e=%b want 0 0 1",
                 c, gnt8, out8, empty8);
      end
      cyc_end();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      cyc_begin(c < 9, 4'(c + 2), 1'b1, 1'b0);
      n_chk++;
      if (c == 0) begin
        if (gnt8 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_first: gnt=%b want 0", gnt8);
        end
      end else if ({gnt8, gid8, out8} !== {1'b1, 4'(c + 1), 4'd1}) begin
        n_fail++;
        $display("FAIL b2b c=%0d: gnt=%b id=%h out=%0d want 1 %h 1",
                 c, gnt8, gid8, out8, 4'(c + 1));
      end
      cyc_end();
    end
  endtask

  task automatic test_random();
    logic [39:0] obs;
    logic [39:0] exp;
    logic        sr;
    for (int i = 0; i < 3000; i++) begin
      sr = ($urandom_range(0, 2) == 0);
      cyc_begin(1'($urandom_range(0, 1)), 4'($urandom), sr,
                $urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        if (k == 0)
          obs = {gnt8, gnt8 ? gid8 : 4'h0, gf8, 32'(out8),
                 full8, empty8, ovf8};
        else
          obs = {gnt4, gnt4 ? gid4 : 4'h0, gf4, 32'(out4),
                 full4, empty4, ovf4};
        exp = {mg[k], mg[k] ? mq[k][0].id : 4'h0, mg[k] && !svc_ready,
               32'(mq[k].size()), mq[k].size() == dep(k),
               mq[k].size() == 0, movf[k]};
        n_chk++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random dut%0d cyc=%0d: got %h want %h",
                   dep(k), cyc, obs, exp);
        end
      end
      cyc_end();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_forced();
    test_stream();
    test_full();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
